// File: rtl/uart_pkg.sv
// Shared UART encodings: TX FSM state codes and line/parity constants (also used by RX checkers).
// Constants only; no latency or backpressure.
package uart_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Parallel-load shift register plus bit counter; ser_bit is the bit that will be on the line after
// this edge (shift applied), ser_done flags the last data bit. Updates in one cycle, no backpressure.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0]      bit_cnt_q;

  assign shift_nxt = shift_q >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (load) begin
      shift_q   <= p_data;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      shift_q   <= shift_nxt;
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  // Look-ahead so the output flop can be fed from the post-edge register value.
  assign ser_bit  = shift_en ? shift_nxt[0] : shift_q[0];
  assign ser_done = (bit_cnt_q == LAST_BIT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop; CLKS_PER_BIT clk per bit.
// tx_out/busy change on the accepting edge; data_valid while busy is dropped, not queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q;
  uart_state_e       state_d;
  logic [BAUD_W-1:0] baud_q;
  logic              baud_wrap;
  logic              par_en_q;
  logic              parity_q;
  logic              load;
  logic              shift_en;
  logic              ser_bit;
  logic              ser_done;
  logic              tx_d;
  logic              busy_d;

  assign baud_wrap = (baud_q == BAUD_MAX);
  assign load      = (state_q == IDLE) && data_valid;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .p_data   (p_data),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE:   if (data_valid) state_d = START;
      START:  if (baud_wrap)  state_d = DATA;
      DATA: begin
        if (baud_wrap) begin
          if (ser_done) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      PARITY: if (baud_wrap)  state_d = STOP;
      STOP:   if (baud_wrap)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the output flop never lags the FSM.
  always_comb begin
    tx_d   = STOP_BIT;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = ser_bit;
      PARITY:  tx_d = parity_q;
      default: tx_d = STOP_BIT;
    endcase
  end

  // Bit transitions happen only on wrap, so the counter restarts at every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q <= '0;
    end else if ((state_q == IDLE) || baud_wrap) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q <= 1'b0;
      parity_q <= PAR_EVEN;
    end else if (load) begin
      par_en_q <= par_en;
      parity_q <= (^p_data) ^ par_typ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_out <= STOP_BIT;
      busy   <= 1'b0;
    end else begin
      tx_out <= tx_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench: two uart_tx instances (4 clk/bit and 1 clk/bit) checked against a frame model.
module tb_uart_tx;

  typedef struct {
    logic [63:0] bits;
    int          len;
    int          start;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       dv0, dv1;
  logic [7:0] pd0, pd1;
  logic       pe0, pe1, pt0, pt1;
  logic       tx0, tx1, busy0, busy1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  frame_t q0[$];
  frame_t q1[$];

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .data_valid(dv0), .p_data(pd0), .par_en(pe0), .par_typ(pt0),
    .tx_out(tx0), .busy(busy0)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_valid(dv1), .p_data(pd1), .par_en(pe1), .par_typ(pt1),
    .tx_out(tx1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: list of line levels, each bit repeated cpb times, optionally cut short.
  function automatic frame_t build(input logic [7:0] data, input logic pe, input logic pt,
                                   input int cpb, input int trunc, input int start);
    frame_t f;
    int     seq[$];
    int     ones;
    f.bits = '0;
    f.len  = 0;
    f.start = start;
    ones = $countones(data);
    seq.push_back(0);
    for (int i = 0; i < 8; i++) seq.push_back((data >> i) & 1);
    if (pe) seq.push_back(pt ? ((ones % 2 == 0) ? 1 : 0) : ((ones % 2 == 1) ? 1 : 0));
    seq.push_back(1);
    foreach (seq[i]) begin
      for (int k = 0; k < cpb; k++) begin
        if (f.len < 64) f.bits[f.len] = seq[i][0];
        f.len++;
      end
    end
    if (trunc > 0 && trunc < f.len) begin
      f.len  = trunc;
      f.bits = f.bits & ((64'd1 << trunc) - 64'd1);
    end
    return f;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  // All stimulus runs in the phase just after a rising edge.
  task automatic wait_idle(input int d);
    int w = 0;
    while (busy_of(d)) begin
      @(posedge clk); #1;
      w++;
      if (w > 200) begin
        chk(1'b0, "idle_wait_timeout", w, 200);
        break;
      end
    end
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic pe, input logic pt,
                      input int trunc, output int start);
    frame_t f;
    wait_idle(d);
    start = cyc + 1;
    if (d == 0) begin
      dv0 = 1'b1; pd0 = data; pe0 = pe; pt0 = pt;
      f = build(data, pe, pt, 4, trunc, start);
      q0.push_back(f);
    end else begin
      dv1 = 1'b1; pd1 = data; pe1 = pe; pt1 = pt;
      f = build(data, pe, pt, 1, trunc, start);
      q1.push_back(f);
    end
    @(posedge clk); #1;
    // Mid-frame input changes must not affect the frame in flight.
    if (d == 0) begin
      dv0 = 1'b0; pd0 = 8'($urandom); pe0 = 1'($urandom); pt0 = 1'($urandom);
    end else begin
      dv1 = 1'b0; pd1 = 8'($urandom); pe1 = 1'($urandom); pt1 = 1'($urandom);
    end
  endtask

  // Monitor: collects the line while busy, compares the whole frame when busy drops.
  logic [63:0] obs [2];
  int          nobs[2];
  int          ostart[2];
  bit          coll[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic   t, b;
      bit     have;
      frame_t e;
      t    = (d == 0) ? tx0 : tx1;
      b    = (d == 0) ? busy0 : busy1;
      have = 1'b0;
      if (b && !coll[d]) begin
        coll[d]   = 1'b1;
        obs[d]    = '0;
        nobs[d]   = 0;
        ostart[d] = cyc;
      end
      if (b) begin
        if (nobs[d] < 64) obs[d][nobs[d]] = t;
        nobs[d]++;
      end else begin
        if (coll[d]) begin
          coll[d] = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          chk(have, "frame_expected", d, 1);
          if (have) begin
            chk(ostart[d] == e.start, "frame_start_cycle", ostart[d], e.start);
            chk(nobs[d] == e.len, "frame_busy_len", nobs[d], e.len);
            chk(obs[d] == e.bits, "frame_bits", obs[d], e.bits);
          end
        end
        chk(t == 1'b1, "idle_line_high", t, 1);
      end
    end
  end

  initial begin
    int s, s2, g;
    dv0 = 0; dv1 = 0; pd0 = 0; pd1 = 0; pe0 = 0; pe1 = 0; pt0 = 0; pt1 = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk(tx0 == 1'b1, "reset_tx0", tx0, 1);
    chk(busy0 == 1'b0, "reset_busy0", busy0, 0);
    chk(tx1 == 1'b1, "reset_tx1", tx1, 1);
    chk(busy1 == 1'b0, "reset_busy1", busy1, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed frames
    send(0, 8'hA5, 1'b0, 1'b0, 0, s);
    send(0, 8'hA5, 1'b1, 1'b0, 0, s);
    send(0, 8'hA5, 1'b1, 1'b1, 0, s);
    send(0, 8'h07, 1'b1, 1'b0, 0, s);
    send(1, 8'h00, 1'b1, 1'b1, 0, s);

    // data_valid held across a frame: second word waits for one idle cycle
    wait_idle(0);
    wait_idle(1);
    dv0 = 1'b1; pd0 = 8'h3C; pe0 = 1'b0; pt0 = 1'b0;
    s = cyc + 1;
    q0.push_back(build(8'h3C, 1'b0, 1'b0, 4, 0, s));
    s2 = s + 40 + 1;
    q0.push_back(build(8'hFF, 1'b0, 1'b0, 4, 0, s2));
    repeat (3) @(posedge clk);
    #1 pd0 = 8'hFF;
    while (cyc < s2) begin @(posedge clk); #1; end
    dv0 = 1'b0;

    // Reset during data bit 3 (bit 3 of 0x96 is 0, so the line is low at abort)
    wait_idle(0);
    wait_idle(1);
    send(0, 8'h96, 1'b0, 1'b0, 17, s);
    while (cyc < s + 17) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk(tx0 == 1'b1, "abort_tx_high", tx0, 1);
    chk(busy0 == 1'b0, "abort_busy_low", busy0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(0, 8'h5A, 1'b1, 1'b1, 0, s);

    // Randomised frames on both instances
    for (int i = 0; i < 24; i++) begin
      g = $urandom_range(0, 1);
      send(g, 8'($urandom), 1'($urandom), 1'($urandom), 0, s);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(posedge clk);
    #1;
    chk(q0.size() == 0, "q0_drained", q0.size(), 0);
    chk(q1.size() == 0, "q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
